// File: rtl/bc_sched.sv
// bc_sched: command scheduler in front of the PWM/UART bitcode sink.
// Plays path bitcodes from the block ROM on ticks; avoidance words preempt and then hold path playback off.
module bc_sched #(
   parameter int                ADDR_W     = 8,
   parameter int                DATA_W     = 16,
   parameter int                ROM_LAT    = 1,
   parameter int                HOLD_TICKS = 16,
   parameter logic [DATA_W-1:0] END_CODE   = 16'hFFFF,
   parameter int                LOOP       = 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              tick,
   input  logic              start,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [DATA_W-1:0] rom_data,
   input  logic [DATA_W-1:0] avd_data,
   input  logic              avd_valid,
   output logic              avd_rdy,
   output logic [DATA_W-1:0] out_data,
   output logic              out_valid,
   input  logic              out_rdy,
   output logic              src,
   output logic              busy,
   output logic              halted
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_WAIT   = 3'd1;
   localparam logic [2:0] S_FETCH  = 3'd2;
   localparam logic [2:0] S_POFFER = 3'd3;
   localparam logic [2:0] S_AOFFER = 3'd4;
   localparam logic [2:0] S_DONE   = 3'd5;

   localparam int                HOLD_W    = $clog2(HOLD_TICKS + 2);
   localparam logic [HOLD_W-1:0] HOLD_LOAD = HOLD_W'(HOLD_TICKS);
   localparam logic [HOLD_W-1:0] HOLD_ONE  = HOLD_W'(1);
   localparam logic [1:0]        LAT_LAST  = 2'(ROM_LAT);
   localparam logic [ADDR_W-1:0] ADDR_ONE  = ADDR_W'(1);

   logic [2:0]        r_state;
   logic [2:0]        r_ret;
   logic [1:0]        r_lat_cnt;
   logic [HOLD_W-1:0] r_hold_cnt;
   logic [ADDR_W-1:0] r_addr;
   logic [DATA_W-1:0] r_data;
   logic              r_valid;
   logic              r_src;
   logic              r_halted;

   logic w_avd_rdy;
   logic w_avd_acc;
   logic w_rom_end;

   assign w_avd_rdy = (r_state == S_IDLE) || (r_state == S_WAIT) || (r_state == S_DONE);
   assign w_avd_acc = avd_valid && w_avd_rdy;
   assign w_rom_end = (rom_data == END_CODE);

   assign rom_addr  = r_addr;
   assign avd_rdy   = w_avd_rdy;
   assign out_data  = r_data;
   assign out_valid = r_valid;
   assign src       = r_src;
   assign busy      = !((r_state == S_IDLE) || (r_state == S_DONE));
   assign halted    = r_halted;

   // An accepted avoidance word always wins; the state it interrupted becomes the return state.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_ret      <= S_IDLE;
         r_lat_cnt  <= 2'd0;
         r_hold_cnt <= '0;
         r_addr     <= '0;
         r_data     <= '0;
         r_valid    <= 1'b0;
         r_src      <= 1'b0;
         r_halted   <= 1'b0;
      end else if (w_avd_acc) begin
         r_ret      <= r_state;
         r_state    <= S_AOFFER;
         r_data     <= avd_data;
         r_valid    <= 1'b1;
         r_src      <= 1'b1;
         r_hold_cnt <= HOLD_LOAD;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (start) begin
                  r_state <= S_WAIT;
               end
            end
            S_WAIT: begin
               if (tick) begin
                  if (r_hold_cnt != '0) begin
                     r_hold_cnt <= r_hold_cnt - HOLD_ONE;
                  end else begin
                     r_state   <= S_FETCH;
                     r_lat_cnt <= 2'd0;
                  end
               end
            end
            // The counter runs one step past ROM_LAT so the sample lands ROM_LAT+1 edges after the tick.
            S_FETCH: begin
               if (r_lat_cnt != LAT_LAST) begin
                  r_lat_cnt <= r_lat_cnt + 2'd1;
               end else if (w_rom_end) begin
                  if (LOOP != 0) begin
                     r_addr  <= '0;
                     r_state <= S_WAIT;
                  end else begin
                     r_halted <= 1'b1;
                     r_state  <= S_DONE;
                  end
               end else begin
                  r_data  <= rom_data;
                  r_valid <= 1'b1;
                  r_src   <= 1'b0;
                  r_state <= S_POFFER;
               end
            end
            S_POFFER: begin
               if (out_rdy) begin
                  r_valid <= 1'b0;
                  r_addr  <= r_addr + ADDR_ONE;
                  r_state <= S_WAIT;
               end
            end
            S_AOFFER: begin
               if (out_rdy) begin
                  r_valid <= 1'b0;
                  r_state <= r_ret;
               end
            end
            S_DONE: begin
               if (start) begin
                  r_halted <= 1'b0;
                  r_addr   <= '0;
                  r_state  <= S_WAIT;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_bc_sched.sv
// tb_bc_sched: two bc_sched instances (halting and looping) checked against a transaction-level reference model,
// a vector table, directed corner-case sequences and randomized stimulus.
module tb_bc_sched;

   localparam int             AW    = 8;
   localparam int             DW    = 16;
   localparam logic [DW-1:0]  ENDC  = 16'hFFFF;
   localparam int             LAT0  = 1;
   localparam int             HOLD0 = 2;
   localparam int             LAT1  = 2;
   localparam int             HOLD1 = 3;

   logic          clk      = 1'b0;
   logic          rstN     = 1'b0;
   logic          tick     = 1'b0;
   logic          start    = 1'b0;
   logic          avdValid = 1'b0;
   logic [DW-1:0] avdData  = '0;
   logic          outRdy   = 1'b0;
   logic          checkEn  = 1'b0;

   logic [AW-1:0] addr0, addr1;
   logic [DW-1:0] romData0, romData1, data0, data1;
   logic          rdy0, rdy1, valid0, valid1, src0, src1, busy0, busy1, halted0, halted1;

   logic [DW-1:0] rom0 [256];
   logic [DW-1:0] rom1 [256];
   logic [DW-1:0] pipe0  = '0;
   logic [DW-1:0] pipe1a = '0;
   logic [DW-1:0] pipe1b = '0;

   int nChecks = 0;
   int nFails  = 0;

   always #5 clk = ~clk;

   // Block ROMs with one and two cycles of read latency.
   always @(posedge clk) begin
      pipe0  <= rom0[addr0];
      pipe1a <= rom1[addr1];
      pipe1b <= pipe1a;
   end
   assign romData0 = pipe0;
   assign romData1 = pipe1b;

   bc_sched #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT0), .HOLD_TICKS(HOLD0), .END_CODE(ENDC), .LOOP(0)) u0 (
      .clk(clk), .rst(rstN), .tick(tick), .start(start), .rom_addr(addr0), .rom_data(romData0),
      .avd_data(avdData), .avd_valid(avdValid), .avd_rdy(rdy0), .out_data(data0), .out_valid(valid0),
      .out_rdy(outRdy), .src(src0), .busy(busy0), .halted(halted0));

   bc_sched #(.ADDR_W(AW), .DATA_W(DW), .ROM_LAT(LAT1), .HOLD_TICKS(HOLD1), .END_CODE(ENDC), .LOOP(1)) u1 (
      .clk(clk), .rst(rstN), .tick(tick), .start(start), .rom_addr(addr1), .rom_data(romData1),
      .avd_data(avdData), .avd_valid(avdValid), .avd_rdy(rdy1), .out_data(data1), .out_valid(valid1),
      .out_rdy(outRdy), .src(src1), .busy(busy1), .halted(halted1));

   logic [28:0] dutOut0, dutOut1;
   assign dutOut0 = {addr0, valid0, data0, src0, busy0, halted0, rdy0};
   assign dutOut1 = {addr1, valid1, data1, src1, busy1, halted1, rdy1};

   typedef enum int {M_IDLE, M_WAIT, M_FETCH, M_POFFER, M_AOFFER, M_DONE} mode_t;

   typedef struct packed {
      mode_t         mode;
      mode_t         ret;
      int            fetchLeft;
      int            hold;
      logic [AW-1:0] addr;
      logic [DW-1:0] data;
      logic          valid;
      logic          src;
      logic          halted;
   } model_t;

   model_t m0, m1;

   function automatic model_t modelReset();
      model_t n;
      n.mode = M_IDLE; n.ret = M_IDLE; n.fetchLeft = 0; n.hold = 0;
      n.addr = '0; n.data = '0; n.valid = 1'b0; n.src = 1'b0; n.halted = 1'b0;
      return n;
   endfunction

   function automatic model_t modelStep(model_t s, int lat, int holdTicks, bit loopEn, logic [DW-1:0] romWord);
      model_t n = s;
      bit takesAvoid = (s.mode == M_IDLE || s.mode == M_WAIT || s.mode == M_DONE) && avdValid;
      if (takesAvoid) begin
         n.ret = s.mode; n.mode = M_AOFFER; n.data = avdData; n.valid = 1'b1; n.src = 1'b1; n.hold = holdTicks;
         return n;
      end
      case (s.mode)
         M_IDLE:   if (start) n.mode = M_WAIT;
         M_WAIT:   if (tick) begin
                      if (s.hold > 0) n.hold = s.hold - 1;
                      else begin n.mode = M_FETCH; n.fetchLeft = lat; end
                   end
         M_FETCH:  if (s.fetchLeft > 0) n.fetchLeft = s.fetchLeft - 1;
                   else if (romWord == ENDC) begin
                      if (loopEn) begin n.addr = '0; n.mode = M_WAIT; end
                      else begin n.halted = 1'b1; n.mode = M_DONE; end
                   end else begin
                      n.data = romWord; n.valid = 1'b1; n.src = 1'b0; n.mode = M_POFFER;
                   end
         M_POFFER: if (outRdy) begin n.valid = 1'b0; n.addr = s.addr + 8'd1; n.mode = M_WAIT; end
         M_AOFFER: if (outRdy) begin n.valid = 1'b0; n.mode = s.ret; end
         M_DONE:   if (start) begin n.halted = 1'b0; n.addr = '0; n.mode = M_WAIT; end
         default:  n.mode = M_IDLE;
      endcase
      return n;
   endfunction

   function automatic logic [28:0] modelOut(model_t s);
      logic idleLike = (s.mode == M_IDLE) || (s.mode == M_DONE);
      logic rdy      = idleLike || (s.mode == M_WAIT);
      return {s.addr, s.valid, s.data, s.src, !idleLike, s.halted, rdy};
   endfunction

   always @(posedge clk or negedge rstN) begin
      if (!rstN) begin
         m0 <= modelReset();
         m1 <= modelReset();
      end else begin
         m0 <= modelStep(m0, LAT0, HOLD0, 1'b0, rom0[m0.addr]);
         m1 <= modelStep(m1, LAT1, HOLD1, 1'b1, rom1[m1.addr]);
      end
   end

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      nChecks++;
      if (act !== exp) begin
         nFails++;
         $display("[TB] FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   always @(posedge clk) begin
      #1;
      if (checkEn) begin
         checkOutput("u0 model", dutOut0, modelOut(m0));
         checkOutput("u1 model", dutOut1, modelOut(m1));
      end
   end

   typedef struct packed {
      logic tk, st, av; logic [DW-1:0] ad; logic ordy;
      logic [AW-1:0] eAddr; logic eValid; logic [DW-1:0] eData; logic eSrc, eBusy, eHalted, eRdy;
   } vec_t;

   function automatic vec_t mv(logic tk, logic st, logic av, logic [DW-1:0] ad, logic ordy, logic [AW-1:0] eAddr,
                               logic eValid, logic [DW-1:0] eData, logic eSrc, logic eBusy, logic eHalted, logic eRdy);
      vec_t v;
      v.tk = tk; v.st = st; v.av = av; v.ad = ad; v.ordy = ordy;
      v.eAddr = eAddr; v.eValid = eValid; v.eData = eData; v.eSrc = eSrc; v.eBusy = eBusy; v.eHalted = eHalted; v.eRdy = eRdy;
      return v;
   endfunction

   task automatic applyStimulus(input logic tk, input logic st, input logic av, input logic [DW-1:0] ad, input logic ordy);
      tick = tk; start = st; avdValid = av; avdData = ad; outRdy = ordy;
   endtask

   task automatic doReset();
      applyStimulus(1'b0, 1'b0, 1'b0, '0, 1'b1);
      @(negedge clk);
      #2 rstN = 1'b0;
      @(negedge clk);
      @(negedge clk);
      rstN = 1'b1;
   endtask

   task automatic waitValid0(output bit ok);
      ok = 1'b0;
      for (int i = 0; i < 12; i++) begin
         if (valid0) begin ok = 1'b1; return; end
         @(negedge clk);
      end
      checkOutput("u0 valid timeout", {31'd0, valid0}, 32'd1);
   endtask

   initial begin
      #1_000_000;
      $display("[TB] FAIL watchdog: simulation did not finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      vec_t          vecs[$];
      bit            ok;
      int            extra;
      logic [DW-1:0] got[$];
      logic [DW-1:0] expWords [4];

      for (int i = 0; i < 256; i++) begin rom0[i] = 16'h0000; rom1[i] = 16'h0000; end
      rom0[0] = 16'h0101; rom0[1] = 16'h0202; rom0[2] = ENDC;
      rom1[0] = 16'h1111; rom1[1] = 16'h2222; rom1[2] = 16'h3333; rom1[3] = ENDC;

      repeat (3) @(negedge clk);
      rstN    = 1'b1;
      checkEn = 1'b1;
      @(negedge clk);
      $display("[TB] reset state");
      checkOutput("reset addr", {24'd0, addr0}, 32'd0);
      checkOutput("reset valid", {31'd0, valid0}, 32'd0);
      checkOutput("reset avd_rdy", {31'd0, rdy0}, 32'd1);
      checkOutput("reset busy", {31'd0, busy0}, 32'd0);
      checkOutput("reset halted", {31'd0, halted0}, 32'd0);
      checkOutput("reset u1 valid", {31'd0, valid1}, 32'd0);

      $display("[TB] vector table: playback, halt, avoid in DONE, hold");
      vecs.push_back(mv(0,1,0,16'h0000,1, 8'd0,0,16'h0000,0,1,0,1));
      vecs.push_back(mv(1,0,0,16'h0000,1, 8'd0,0,16'h0000,0,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd0,0,16'h0000,0,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd0,1,16'h0101,0,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd1,0,16'h0101,0,1,0,1));
      vecs.push_back(mv(1,0,0,16'h0000,1, 8'd1,0,16'h0101,0,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd1,0,16'h0101,0,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd1,1,16'h0202,0,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd2,0,16'h0202,0,1,0,1));
      vecs.push_back(mv(1,0,0,16'h0000,1, 8'd2,0,16'h0202,0,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd2,0,16'h0202,0,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd2,0,16'h0202,0,0,1,1));
      vecs.push_back(mv(1,0,0,16'h0000,1, 8'd2,0,16'h0202,0,0,1,1));
      vecs.push_back(mv(0,0,1,16'h0A0A,0, 8'd2,1,16'h0A0A,1,1,1,0));
      vecs.push_back(mv(0,1,0,16'h0000,0, 8'd2,1,16'h0A0A,1,1,1,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd2,0,16'h0A0A,1,0,1,1));
      vecs.push_back(mv(0,1,0,16'h0000,1, 8'd0,0,16'h0A0A,1,1,0,1));
      vecs.push_back(mv(1,0,0,16'h0000,1, 8'd0,0,16'h0A0A,1,1,0,1));
      vecs.push_back(mv(1,0,0,16'h0000,1, 8'd0,0,16'h0A0A,1,1,0,1));
      vecs.push_back(mv(1,0,0,16'h0000,1, 8'd0,0,16'h0A0A,1,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd0,0,16'h0A0A,1,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd0,1,16'h0101,0,1,0,0));
      vecs.push_back(mv(0,0,0,16'h0000,1, 8'd1,0,16'h0101,0,1,0,1));
      for (int i = 0; i < vecs.size(); i++) begin
         applyStimulus(vecs[i].tk, vecs[i].st, vecs[i].av, vecs[i].ad, vecs[i].ordy);
         @(negedge clk);
         checkOutput($sformatf("vec[%0d]", i), {3'd0, dutOut0},
                     {3'd0, vecs[i].eAddr, vecs[i].eValid, vecs[i].eData, vecs[i].eSrc,
                      vecs[i].eBusy, vecs[i].eHalted, vecs[i].eRdy});
      end

      $display("[TB] backpressure");
      doReset();
      applyStimulus(0, 1, 0, '0, 0); @(negedge clk);
      applyStimulus(1, 0, 0, '0, 0); @(negedge clk);
      applyStimulus(0, 0, 0, '0, 0);
      waitValid0(ok);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(i % 2 == 0, 0, 0, '0, 0);
         @(negedge clk);
         checkOutput("bp data", {16'd0, data0}, 32'h0101);
         checkOutput("bp valid", {31'd0, valid0}, 32'd1);
         checkOutput("bp avd_rdy", {31'd0, rdy0}, 32'd0);
         checkOutput("bp addr", {24'd0, addr0}, 32'd0);
      end
      applyStimulus(0, 0, 0, '0, 1); @(negedge clk);
      checkOutput("bp accept valid", {31'd0, valid0}, 32'd0);
      checkOutput("bp accept addr", {24'd0, addr0}, 32'd1);
      extra = 0;
      repeat (5) begin @(negedge clk); if (valid0) extra++; end
      checkOutput("bp extra accepts", extra, 32'd0);
      checkOutput("bp final addr", {24'd0, addr0}, 32'd1);

      $display("[TB] avoid preemption and hold");
      applyStimulus(1, 0, 1, 16'h0A0A, 0); @(negedge clk);
      checkOutput("avd valid", {31'd0, valid0}, 32'd1);
      checkOutput("avd data", {16'd0, data0}, 32'h0A0A);
      checkOutput("avd src", {31'd0, src0}, 32'd1);
      applyStimulus(0, 0, 0, '0, 1); @(negedge clk);
      checkOutput("avd accepted", {31'd0, valid0}, 32'd0);
      extra = 0;
      for (int t = 0; t < 2; t++) begin
         applyStimulus(1, 0, 0, '0, 1); @(negedge clk);
         applyStimulus(0, 0, 0, '0, 1);
         repeat (3) begin @(negedge clk); if (valid0) extra++; end
      end
      checkOutput("hold no output", extra, 32'd0);
      checkOutput("hold addr", {24'd0, addr0}, 32'd1);
      applyStimulus(1, 0, 0, '0, 0); @(negedge clk);
      applyStimulus(0, 0, 0, '0, 0);
      waitValid0(ok);
      checkOutput("post-hold data", {16'd0, data0}, 32'h0202);
      checkOutput("post-hold src", {31'd0, src0}, 32'd0);
      checkOutput("post-hold addr", {24'd0, addr0}, 32'd1);

      $display("[TB] loop wrap");
      doReset();
      applyStimulus(0, 1, 0, '0, 1); @(negedge clk);
      applyStimulus(0, 0, 0, '0, 1);
      for (int t = 0; t < 5; t++) begin
         if (t == 4) checkOutput("wrap addr", {24'd0, addr1}, 32'd0);
         applyStimulus(1, 0, 0, '0, 1); @(negedge clk);
         applyStimulus(0, 0, 0, '0, 1);
         repeat (7) begin
            if (valid1 && outRdy) got.push_back(data1);
            @(negedge clk);
         end
         if (t == 2) checkOutput("wrap addr after 3 words", {24'd0, addr1}, 32'd3);
      end
      expWords[0] = 16'h1111; expWords[1] = 16'h2222; expWords[2] = 16'h3333; expWords[3] = 16'h1111;
      checkOutput("wrap word count", got.size(), 32'd4);
      for (int i = 0; i < 4 && i < got.size(); i++)
         checkOutput($sformatf("wrap word[%0d]", i), {16'd0, got[i]}, {16'd0, expWords[i]});

      $display("[TB] reset mid-operation");
      doReset();
      applyStimulus(0, 0, 1, 16'h0C0C, 0); @(negedge clk);
      applyStimulus(0, 0, 0, '0, 0);
      checkOutput("mid avoid valid", {31'd0, valid0}, 32'd1);
      #2 rstN = 1'b0;
      #1;
      checkOutput("async valid drop", {31'd0, valid0}, 32'd0);
      checkOutput("async busy drop", {31'd0, busy0}, 32'd0);
      checkOutput("async u1 valid drop", {31'd0, valid1}, 32'd0);
      @(negedge clk);
      rstN = 1'b1;
      applyStimulus(0, 1, 0, '0, 1); @(negedge clk);
      applyStimulus(1, 0, 0, '0, 1); @(negedge clk);
      applyStimulus(0, 0, 0, '0, 1);
      waitValid0(ok);
      checkOutput("replay data", {16'd0, data0}, 32'h0101);
      checkOutput("replay addr", {24'd0, addr0}, 32'd0);

      $display("[TB] randomized run");
      applyStimulus(0, 0, 0, '0, 1);
      @(negedge clk);
      #2 rstN = 1'b0;
      for (int i = 0; i < 256; i++) begin
         rom0[i] = ($urandom_range(0, 5) == 0) ? ENDC : 16'($urandom);
         rom1[i] = ($urandom_range(0, 5) == 0) ? ENDC : 16'($urandom);
      end
      @(negedge clk);
      rstN = 1'b1;
      for (int c = 0; c < 3000; c++) begin
         applyStimulus($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 7) == 0,
                       16'($urandom), $urandom_range(0, 3) != 0);
         rstN = ($urandom_range(0, 399) != 0);
         @(negedge clk);
      end
      rstN = 1'b1;
      applyStimulus(0, 0, 0, '0, 1);
      repeat (3) @(negedge clk);

      $display("End of test - %0d assertions evaluated, %0d failures", nChecks, nFails);
      $finish;
   end

endmodule
